// File: rtl/serial_sub_xb.sv
// serial_sub_xb: bit-serial LSB-first subtractor diff = inA - inB - bin with start/busy/done handshake
module serial_sub_xb #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);
   localparam int CW = $clog2(WIDTH) + 1;
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] opa, opb, sh, sh_n;
   logic br, br_n, sa, sb, d, accept, last;
   always_comb begin
      d       = opa[0] ^ opb[0] ^ br;
      br_n    = (~opa[0] & opb[0]) | (~(opa[0] ^ opb[0]) & br);
      sh_n    = {d, sh[WIDTH-1:1]};
      accept  = state == IDLE && start;
      last    = state == RUN && cnt == CW'(WIDTH - 1);
      state_n = accept ? RUN : last ? IDLE : state;
   end
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_n;
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         opa  <= '0;
         opb  <= '0;
         sh   <= '0;
         br   <= 1'b0;
         sa   <= 1'b0;
         sb   <= 1'b0;
         done <= 1'b0;
         diff <= '0;
         bout <= 1'b0;
         ovf  <= 1'b0;
         zero <= 1'b0;
      end else begin
         done <= last;
         if (accept) begin
            opa <= inA;
            opb <= inB;
            br  <= bin;
            sa  <= inA[WIDTH-1];
            sb  <= inB[WIDTH-1];
            sh  <= '0;
            cnt <= '0;
         end else if (state == RUN) begin
            opa <= opa >> 1;
            opb <= opb >> 1;
            br  <= br_n;
            sh  <= sh_n;
            cnt <= cnt + 1'b1;
         end
         // overflow judged from the operand signs captured at accept, not the shifted copies
         if (last) begin
            diff <= sh_n;
            bout <= br_n;
            zero <= sh_n == '0;
            ovf  <= (sa ^ sb) & (d ^ sa);
         end
      end
   end
   assign busy = state == RUN;
endmodule

// File: tb/tb_serial_sub_xb.sv
// tb_serial_sub_xb: directed and random checks of serial_sub_xb against an arithmetic model
module tb_serial_sub_xb;
   localparam int W = 8;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, bin = 1'b0;
   logic [W-1:0] inA = '0, inB = '0, diff;
   logic busy, done, bout, ovf, zero;
   int total = 0, bad = 0;

   serial_sub_xb #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .inA(inA), .inB(inB), .bin(bin),
      .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      @(negedge clk);
      inA = a; inB = b; bin = bi; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // already = number of edges after the accept edge that have passed
   task automatic wait_done(input string tag, input int already,
                            input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      int cyc = already;
      int r;
      logic [W-1:0] held = diff, ed;
      logic stable = 1'b1, busy_ok = 1'b1, ebout, eovf;
      while (done !== 1'b1 && cyc < 40) begin
         if (diff !== held) stable = 1'b0;
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
         cyc++;
      end
      r     = int'(a) - int'(b) - int'(bi);
      ed    = r[W-1:0];
      ebout = r < 0;
      eovf  = (a[W-1] != b[W-1]) && (ed[W-1] != a[W-1]);
      chk({tag, ".latency"}, cyc, W);
      chk({tag, ".busy_run"}, busy_ok, 1'b1);
      chk({tag, ".held"}, stable, 1'b1);
      chk({tag, ".busy_done"}, busy, 1'b0);
      chk({tag, ".diff"}, diff, ed);
      chk({tag, ".bout"}, bout, ebout);
      chk({tag, ".ovf"}, ovf, eovf);
      chk({tag, ".zero"}, zero, ed == '0);
      chk({tag, ".inverse"}, W'(diff + inB_hold(b) + W'(bi)), a);
   endtask

   function automatic logic [W-1:0] inB_hold(input logic [W-1:0] b);
      return b;
   endfunction

   task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      launch(a, b, bi);
      wait_done(tag, 0, a, b, bi);
      @(negedge clk);
      chk({tag, ".done_pulse"}, done, 1'b0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst.busy", busy, 1'b0);
      chk("rst.done", done, 1'b0);
      chk("rst.diff", diff, '0);
      chk("rst.flags", {bout, ovf, zero}, 3'b000);
      rst = 1'b0;
      op("t1", 8'h5A, 8'h3C, 1'b0);
      op("t2", 8'h00, 8'h01, 1'b0);
      op("t3a", 8'h80, 8'h01, 1'b0);
      op("t3b", 8'h7F, 8'hFF, 1'b0);
      op("t4a", 8'h10, 8'h0F, 1'b1);
      op("t4b", 8'h00, 8'h00, 1'b1);
      // second start mid-run must be ignored
      launch(8'h33, 8'h11, 1'b0);
      @(negedge clk);
      @(negedge clk);
      inA = 8'hFF; inB = 8'h01; bin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("t5a", 3, 8'h33, 8'h11, 1'b0);
      // start raised in the done cycle is accepted
      inA = 8'h44; inB = 8'h04; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t5b.busy", busy, 1'b1);
      wait_done("t5b", 0, 8'h44, 8'h04, 1'b0);
      // reset on E4 aborts the op
      launch(8'h5A, 8'h3C, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6.busy", busy, 1'b0);
      chk("t6.diff", diff, '0);
      chk("t6.flags", {done, bout, ovf, zero}, 4'b0000);
      begin
         logic seen = 1'b0;
         repeat (12) begin
            @(negedge clk);
            if (done) seen = 1'b1;
         end
         chk("t6.no_done", seen, 1'b0);
      end
      for (int i = 0; i < 1500; i++) begin
         logic [W-1:0] a = W'($urandom), b = W'($urandom);
         logic bi = 1'($urandom);
         op("soak", a, b, bi);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
